points_fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one points circular FIFO among NUM_REQ point producers.

---
 rtl/alfa_points_pkg.sv | 27 ++
 rtl/alib_rr_arbiter.sv | 41 ++++
 rtl/points_fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_points_fifo_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alfa_points_pkg.sv
// Shared definitions for the points datapath: the default coordinate width,
// the default FIFO depth, and the packed point record. The arbiter and
// points_circular_fifo both use these.
package alfa_points_pkg;

  localparam int COORD_W    = 16;
  localparam int FIFO_DEPTH = 16;

  // One point as stored in the FIFO: {x, y, z}, with x in the top bits.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  // Builds a point record from its separate coordinates.
  function automatic point_t make_point(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic [COORD_W-1:0] z);
    point_t p;
    p.x = x;
    p.y = y;
    p.z = z;
    return p;
  endfunction

endpackage

// File: rtl/alib_rr_arbiter.sv
// Generic round-robin arbiter. It is purely combinational; the caller owns the
// rotating pointer. Starting at rr_ptr and wrapping upward, the first asserted
// request wins. Nothing is granted when en is low or when no request is set.
module alib_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // Returns (base + off) mod NUM_REQ. This also works when NUM_REQ is not a
  // power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down to offset 0. The last hit overwrites
  // the earlier ones, so the request nearest to rr_ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en && req[wrap_add(rr_ptr, k)]) begin
        grant                       = '0;
        grant[wrap_add(rr_ptr, k)]  = 1'b1;
        grant_idx                   = wrap_add(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/points_fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one points circular FIFO among
// NUM_REQ producers. At most one point per cycle is accepted and registered
// onto the FIFO write port.
//
// A local credit counter tracks FIFO occupancy. It counts a point when the
// point is accepted, one cycle before the FIFO sees the write. Because of
// this, the registered write can never land on a full FIFO.
module points_fifo_wr_arbiter
  import alfa_points_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = alfa_points_pkg::FIFO_DEPTH,
  parameter int COORD_W    = alfa_points_pkg::COORD_W,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*COORD_W-1:0] req_z,
  output logic                       fifo_wr_en,
  output logic [COORD_W-1:0]         fifo_x,
  output logic [COORD_W-1:0]         fifo_y,
  output logic [COORD_W-1:0]         fifo_z,
  input  logic                       fifo_rd_en,
  input  logic                       fifo_empty,
  output logic [IDX_W-1:0]           grant_id,
  output logic [OCC_W-1:0]           occupancy
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               credit_ok;
  logic               xfer;
  logic               rd_dec;
  logic [COORD_W-1:0] sel_x, sel_y, sel_z;

  // Arbitration is allowed only when a FIFO slot is free and reset is low.
  // The credit check uses the registered count, so a read on the FIFO side
  // reaches ready one cycle later. There is no combinational path from read
  // to ready.
  assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign rd_dec    = fifo_rd_en && !fifo_empty && (occupancy != '0);

  alib_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .en        (credit_ok && !rst),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Route the winning producer's coordinates through the one-hot grant.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_z = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x = req_x[i*COORD_W +: COORD_W];
        sel_y = req_y[i*COORD_W +: COORD_W];
        sel_z = req_z[i*COORD_W +: COORD_W];
      end
    end
  end

  // This block holds the output register, the round-robin pointer and the
  // credit counter. It reads and writes them on the same clock edge.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every read in this block
    // sees the value from before the edge. Blocking assignments would let a
    // later read observe a value updated at this same edge.
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_x     <= '0;
      fifo_y     <= '0;
      fifo_z     <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      occupancy  <= '0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        fifo_x   <= sel_x;
        fifo_y   <= sel_y;
        fifo_z   <= sel_z;
        grant_id <= grant_idx;
        rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (xfer && !rd_dec) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (!xfer && rd_dec) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_points_fifo_wr_arbiter.sv
// Directed bench for points_fifo_wr_arbiter with the default parameters
// (4 requesters, depth 16, 16-bit coordinates).
module tb_points_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 16;
  localparam int CW      = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*CW-1:0] req_x, req_y, req_z;
  logic                  fifo_wr_en;
  logic [CW-1:0]         fifo_x, fifo_y, fifo_z;
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [1:0]            grant_id;
  logic [4:0]            occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  points_fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (DEPTH),
    .COORD_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .fifo_wr_en (fifo_wr_en),
    .fifo_x     (fifo_x),
    .fifo_y     (fifo_y),
    .fifo_z     (fifo_z),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .grant_id   (grant_id),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  // Advance one clock. Registered outputs are sampled 1 time unit after the
  // edge, and new inputs are driven at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads requester i with the point (100*i+1, 100*i+2, 100*i+3).
  task automatic load_default_points();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[i*CW +: CW] = CW'(100*i + 1);
      req_y[i*CW +: CW] = CW'(100*i + 2);
      req_z[i*CW +: CW] = CW'(100*i + 3);
    end
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'b1111;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    load_default_points();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    step();
    step();
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en);
    end
    n_cmp++;
    if ({fifo_x, fifo_y, fifo_z} !== 48'd0) begin
      n_fail++; $display("FAIL reset_xyz: got %0d/%0d/%0d want 0/0/0", fifo_x, fifo_y, fifo_z);
    end
    n_cmp++;
    if (grant_id !== 2'd0 || occupancy !== 5'd0) begin
      n_fail++; $display("FAIL reset_gid_occ: got %0d/%0d want 0/0", grant_id, occupancy);
    end
    rst       = 1'b0;
    req_valid = '0;
  endtask

  // All four requesters stay valid, so grants rotate 0,1,2,3,0,... and the
  // write port follows one cycle behind.
  task automatic test_round_robin();
    int exp_g;
    apply_reset();
    load_default_points();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_g = k % NUM_REQ;
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << exp_g)) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_g));
      end
      step();
      n_cmp++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'(exp_g) || fifo_x !== CW'(100*exp_g + 1)) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got wr=%b gid=%0d x=%0d want wr=1 gid=%0d x=%0d",
                 k, fifo_wr_en, grant_id, fifo_x, exp_g, 100*exp_g + 1);
      end
    end
    n_cmp++;
    if (occupancy !== 5'd8) begin
      n_fail++; $display("FAIL rr_occupancy: got %0d want 8", occupancy);
    end
    req_valid = '0;
    step();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || grant_id !== 2'd3 || fifo_z !== CW'(303)) begin
      n_fail++; $display("FAIL rr_idle_hold: got wr=%b gid=%0d z=%0d want wr=0 gid=3 z=303",
                         fifo_wr_en, grant_id, fifo_z);
    end
  endtask

  // Requester 2 alone offers (10,20,30) for one cycle.
  task automatic test_single();
    apply_reset();
    load_default_points();
    req_x[2*CW +: CW] = CW'(10);
    req_y[2*CW +: CW] = CW'(20);
    req_z[2*CW +: CW] = CW'(30);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    n_cmp++;
    if (fifo_wr_en !== 1'b1 || fifo_x !== CW'(10) || fifo_y !== CW'(20) ||
        fifo_z !== CW'(30) || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_write: got wr=%b %0d/%0d/%0d gid=%0d want wr=1 10/20/30 gid=2",
                         fifo_wr_en, fifo_x, fifo_y, fifo_z, grant_id);
    end
    step();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || fifo_x !== CW'(10) || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL single_hold: got wr=%b x=%0d gid=%0d want wr=0 x=10 gid=2",
                         fifo_wr_en, fifo_x, grant_id);
    end
  endtask

  // Only requester 3 is valid while rr_ptr=0. After the grant the pointer
  // wraps to 0, so requester 0 must win when 0 and 3 both request.
  task automatic test_wrap();
    apply_reset();
    load_default_points();
    req_valid = 4'b1000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_ready: got %b want 1000", req_ready);
    end
    step();
    n_cmp++;
    if (grant_id !== 2'd3 || fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL wrap_gid: got gid=%0d wr=%b want 3/1", grant_id, fifo_wr_en);
    end
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    step();
  endtask

  // With no reads, exactly DEPTH transfers fill the credits. One read frees
  // exactly one more transfer.
  task automatic test_full();
    int n_xfer;
    apply_reset();
    load_default_points();
    req_valid = 4'b1111;
    n_xfer = 0;
    for (int k = 0; k < 24; k++) begin
      #1;
      if (|(req_valid & req_ready)) n_xfer++;
      step();
    end
    n_cmp++;
    if (n_xfer !== DEPTH) begin
      n_fail++; $display("FAIL full_count: got %0d want %0d", n_xfer, DEPTH);
    end
    n_cmp++;
    if (occupancy !== 5'd16 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL full_state: got occ=%0d ready=%b want 16/0000", occupancy, req_ready);
    end
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL full_no_comb_path: got %b want 0000", req_ready);
    end
    step();
    fifo_rd_en = 1'b0;
    n_cmp++;
    if (occupancy !== 5'd15) begin
      n_fail++; $display("FAIL full_after_read: got %0d want 15", occupancy);
    end
    n_xfer = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (|(req_valid & req_ready)) n_xfer++;
      step();
    end
    n_cmp++;
    if (n_xfer !== 1 || occupancy !== 5'd16) begin
      n_fail++; $display("FAIL full_refill: got xfers=%0d occ=%0d want 1/16", n_xfer, occupancy);
    end
    req_valid  = '0;
    fifo_empty = 1'b1;
  endtask

  // Checks a simultaneous transfer and read, a read while the FIFO reports
  // empty, a plain read, and that the counter never goes below 0.
  task automatic test_same_cycle();
    apply_reset();
    load_default_points();
    fifo_empty = 1'b0;
    req_valid  = 4'b0001;
    for (int k = 0; k < 5; k++) step();
    n_cmp++;
    if (occupancy !== 5'd5) begin
      n_fail++; $display("FAIL occ_fill5: got %0d want 5", occupancy);
    end
    fifo_rd_en = 1'b1;
    step();
    n_cmp++;
    if (occupancy !== 5'd5 || fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL occ_both: got occ=%0d wr=%b want 5/1", occupancy, fifo_wr_en);
    end
    req_valid  = '0;
    fifo_empty = 1'b1;
    step();
    n_cmp++;
    if (occupancy !== 5'd5) begin
      n_fail++; $display("FAIL occ_empty_read: got %0d want 5", occupancy);
    end
    fifo_empty = 1'b0;
    step();
    n_cmp++;
    if (occupancy !== 5'd4) begin
      n_fail++; $display("FAIL occ_read: got %0d want 4", occupancy);
    end
    apply_reset();
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b0;
    step();
    n_cmp++;
    if (occupancy !== 5'd0) begin
      n_fail++; $display("FAIL occ_underflow: got %0d want 0", occupancy);
    end
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
  endtask

  // Reset lands while transfers are streaming. The in-flight write must be
  // dropped, and arbitration must restart at requester 0.
  task automatic test_mid_reset();
    apply_reset();
    load_default_points();
    req_valid = 4'b1111;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ready: got %b want 0000", req_ready);
    end
    step();
    n_cmp++;
    if (fifo_wr_en !== 1'b0 || occupancy !== 5'd0) begin
      n_fail++; $display("FAIL midrst_state: got wr=%b occ=%0d want 0/0", fifo_wr_en, occupancy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_restart: got %b want 0001", req_ready);
    end
    step();
    n_cmp++;
    if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || occupancy !== 5'd1) begin
      n_fail++; $display("FAIL midrst_first: got gid=%0d wr=%b occ=%0d want 0/1/1",
                         grant_id, fifo_wr_en, occupancy);
    end
    req_valid = '0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_z      = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_full();
    test_same_cycle();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
